// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction encodings, step actions and load clamp for the up/down counter
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_STEP = 2'd1,
    ACT_LOAD = 2'd2
  } count_act_e;

  // Loads above the counting range land on the top value rather than aliasing.
  function automatic int unsigned clamp_to_mod(input int unsigned value, input int unsigned modulus);
    return (value < modulus) ? value : modulus - 1;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// rtl/count_prescaler.sv - enable-gated divide-by-DIV prescaler producing a registered step strobe
module count_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk1,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;

  always_comb begin
    pcnt_nxt = pcnt;
    if (clr) begin
      pcnt_nxt = '0;
    end else if (en) begin
      pcnt_nxt = (pcnt == LAST) ? '0 : pcnt + PW'(1);
    end
  end

  // tick mirrors the phase the prescaler is about to sit in, so it is a clean flop output.
  always_ff @(posedge clk1) begin
    if (Reset) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= pcnt_nxt;
      tick <= (pcnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - modulo-N up/down counter with prescaler, wrap/saturate, load and cascade carry
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH,
  parameter int DIV     = 1
) (
  input  logic             clk1,
  input  logic             Reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             tick
);

  import counter_pkg::*;

  localparam int              EW      = WIDTH + 1;
  localparam logic [EW-1:0]   TOP_EXT = EW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);

  logic [EW-1:0]    cnt_ext;
  logic [EW-1:0]    inc_ext;
  logic [EW-1:0]    dec_ext;
  logic             over;
  logic             under;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  count_act_e       act;

  count_prescaler #(.DIV(DIV)) u_prescaler (
    .clk1  (clk1),
    .Reset (Reset),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // One extra bit exposes both the carry past the top and the borrow below zero.
  assign cnt_ext = {1'b0, count};
  assign inc_ext = cnt_ext + EW'(1);
  assign dec_ext = cnt_ext - EW'(1);
  assign over    = (inc_ext > TOP_EXT);
  assign under   = dec_ext[WIDTH];

  assign at_top = (count == TOP);
  assign at_bot = (count == '0);
  assign tc     = en & tick & ((up_dn == DIR_UP) ? at_top : at_bot);

  assign load_clamped = WIDTH'(clamp_to_mod(32'(load_val), MODULUS));

  always_comb begin
    act = ACT_HOLD;
    if (load) begin
      act = ACT_LOAD;
    end else if (en && tick) begin
      act = ACT_STEP;
    end
  end

  always_comb begin
    step_val  = count;
    step_wrap = 1'b0;
    if (up_dn == DIR_UP) begin
      if (over) begin
        step_val  = sat_mode ? TOP : '0;
        step_wrap = ~sat_mode;
      end else begin
        step_val = inc_ext[WIDTH-1:0];
      end
    end else begin
      if (under) begin
        step_val  = sat_mode ? '0 : TOP;
        step_wrap = ~sat_mode;
      end else begin
        step_val = dec_ext[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    case (act)
      ACT_LOAD: count_nxt = load_clamped;
      ACT_STEP: begin
        count_nxt = step_val;
        wrap_nxt  = step_wrap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (Reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk1) begin
    if (Reset) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench for param_updown_counter (DIV=1, DIV=3 and a decade cascade)
module tb_param_updown_counter;

  localparam int K_CNT  = 0;
  localparam int K_WRAP = 1;
  localparam int K_TC   = 2;
  localparam int K_TICK = 3;
  localparam int K_C3   = 4;
  localparam int K_T3   = 5;
  localparam int K_CAS  = 6;

  typedef struct {
    string name;
    int    due;
    int    kind;
    int    want;
  } exp_t;

  logic       clk1 = 1'b0;
  logic       rst, en, up_dn, sat, ld;
  logic [3:0] lv;
  logic [3:0] count;
  logic       tc, wrap_pulse, tick;

  logic       d3_en;
  logic [3:0] d3_count;
  logic       d3_tc, d3_wrap, d3_tick;

  logic       cas_en;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, lo_wrap, lo_tick, hi_tc, hi_wrap, hi_tick;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_act;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_dut (
    .clk1(clk1), .Reset(rst), .en(en), .up_dn(up_dn), .sat_mode(sat), .load(ld), .load_val(lv),
    .count(count), .tc(tc), .wrap_pulse(wrap_pulse), .tick(tick)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(3)) u_d3 (
    .clk1(clk1), .Reset(rst), .en(d3_en), .up_dn(1'b1), .sat_mode(1'b0), .load(1'b0), .load_val(4'd0),
    .count(d3_count), .tc(d3_tc), .wrap_pulse(d3_wrap), .tick(d3_tick)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_lo (
    .clk1(clk1), .Reset(rst), .en(cas_en), .up_dn(1'b1), .sat_mode(1'b0), .load(1'b0), .load_val(4'd0),
    .count(lo_count), .tc(lo_tc), .wrap_pulse(lo_wrap), .tick(lo_tick)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_hi (
    .clk1(clk1), .Reset(rst), .en(lo_tc), .up_dn(1'b1), .sat_mode(1'b0), .load(1'b0), .load_val(4'd0),
    .count(hi_count), .tc(hi_tc), .wrap_pulse(hi_wrap), .tick(hi_tick)
  );

  function automatic int actual_of(input int kind);
    case (kind)
      K_CNT:   return int'(count);
      K_WRAP:  return int'(wrap_pulse);
      K_TC:    return int'(tc);
      K_TICK:  return int'(tick);
      K_C3:    return int'(d3_count);
      K_T3:    return int'(d3_tick);
      K_CAS:   return int'(hi_count) * 10 + int'(lo_count);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk1) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = actual_of(mon_e.kind);
      n_chk   = n_chk + 1;
      if (mon_act != mon_e.want) begin
        n_fail = n_fail + 1;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", mon_e.name, cyc, mon_act, mon_e.want);
      end
    end
  end

  task automatic push(input string nm, input int due, input int kind, input int want);
    exp_t e;
    e.name = nm;
    e.due  = due;
    e.kind = kind;
    e.want = want;
    sb.push_back(e);
  endtask

  task automatic edge_wait();
    @(posedge clk1);
    #1;
  endtask

  // Main DUT cycle: etc is the tc value within this cycle, the rest are post-edge; -1 skips.
  task automatic cyc1(input logic r, input logic e, input logic u, input logic s, input logic l,
                      input logic [3:0] v, input string nm, input int ecnt, input int ewrap,
                      input int etc, input int etick);
    rst = r; en = e; up_dn = u; sat = s; ld = l; lv = v;
    if (etc >= 0) push({nm, "_tc"}, cyc, K_TC, etc);
    push({nm, "_count"}, cyc + 1, K_CNT, ecnt);
    push({nm, "_wrap"}, cyc + 1, K_WRAP, ewrap);
    if (etick >= 0) push({nm, "_tick"}, cyc + 1, K_TICK, etick);
    edge_wait();
  endtask

  task automatic cyc3(input logic e, input string nm, input int etick_now, input int ecnt);
    d3_en = e;
    push({nm, "_tick"}, cyc, K_T3, etick_now);
    push({nm, "_count"}, cyc + 1, K_C3, ecnt);
    edge_wait();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat = 1'b0; ld = 1'b0; lv = 4'd0;
    d3_en = 1'b0; cas_en = 1'b0;
    edge_wait();

    // Reset dominates load and enable; tc stays low because tick is cleared.
    cyc1(1, 1, 0, 0, 1, 4'd5, "reset1", 0, 0, -1, 0);
    cyc1(1, 1, 0, 0, 1, 4'd5, "reset2", 0, 0, 0, 0);
    cyc1(0, 0, 1, 0, 0, 4'd0, "idle", 0, 0, 0, 1);

    for (int i = 1; i <= 12; i++)
      cyc1(0, 1, 1, 0, 0, 4'd0, "up_wrap", i % 10, (i == 10) ? 1 : 0, (i == 10) ? 1 : 0, 1);

    cyc1(0, 1, 1, 0, 1, 4'd0, "load0", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc1(0, 1, 0, 1, 0, 4'd0, "sat_dn", 0, 0, 1, -1);
    cyc1(0, 1, 0, 0, 0, 4'd0, "wrap_dn", 9, 1, 1, -1);
    cyc1(0, 1, 0, 0, 0, 4'd0, "dn", 8, 0, 0, -1);
    cyc1(0, 1, 1, 0, 0, 4'd0, "dir_up", 9, 0, 0, -1);
    cyc1(0, 1, 1, 0, 0, 4'd0, "up_wrap2", 0, 1, 1, -1);
    cyc1(0, 1, 1, 0, 1, 4'd7, "load7", 7, 0, 0, -1);
    cyc1(0, 1, 1, 0, 1, 4'd12, "load12", 9, 0, 0, -1);
    cyc1(0, 1, 1, 0, 1, 4'd15, "load_term", 9, 0, 1, -1);
    cyc1(0, 1, 1, 1, 0, 4'd0, "sat_up", 9, 0, 1, -1);
    cyc1(0, 0, 1, 0, 0, 4'd0, "hold", 9, 0, 0, -1);
    cyc1(0, 0, 1, 0, 1, 4'd4, "load4", 4, 0, 0, 1);
    cyc1(0, 1, 1, 0, 0, 4'd0, "to5", 5, 0, 0, -1);
    cyc1(1, 1, 1, 0, 1, 4'd3, "rst_load", 0, 0, 0, 0);
    cyc1(0, 0, 1, 0, 0, 4'd0, "idle2", 0, 0, 0, 1);

    // Divide-by-3: steps on every third enabled cycle, frozen while disabled.
    for (int i = 1; i <= 9; i++)
      cyc3(1, "div3_run", (i % 3 == 0) ? 1 : 0, i / 3);
    for (int i = 0; i < 5; i++)
      cyc3(0, "div3_hold", 0, 3);
    for (int i = 1; i <= 3; i++)
      cyc3(1, "div3_resume", (i == 3) ? 1 : 0, (i == 3) ? 4 : 3);
    d3_en = 1'b0;

    // Decade cascade: low tc enables the high digit.
    for (int i = 1; i <= 100; i++) begin
      cas_en = 1'b1;
      push("cascade", cyc + 1, K_CAS, i % 100);
      edge_wait();
    end
    cas_en = 1'b0;
    push("cascade_hold", cyc + 1, K_CAS, 0);
    edge_wait();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk1);
    #1;
    if (sb.size() > 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, 4, count register width in bits (>=1).
REQ-002 SHALL have parameter MODULUS, 2**WIDTH, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 SHALL have parameter DIV, 1, prescale ratio: one count step per DIV enabled cycles (>=1).
REQ-004 SHALL have port clk1 input 1: single clock; all state on rising edge.
REQ-005 SHALL have port Reset input 1: synchronous, active-high reset.
REQ-006 SHALL have port en input 1: count enable; gates prescaler and stepping.
REQ-007 SHALL have port up_dn input 1: 1 = count up, 0 = count down; sampled every cycle.
REQ-008 SHALL have port sat_mode input 1: 0 = wrap at range ends, 1 = saturate.
REQ-009 SHALL have port load input 1: synchronous parallel load strobe.
REQ-010 SHALL have port load_val input WIDTH: value for load.
REQ-011 SHALL have port count output WIDTH: registered count value.
REQ-012 SHALL have port tc output 1: combinational terminal-count/carry for cascading.
REQ-013 SHALL have port wrap_pulse output 1: registered one-cycle wrap indication.
REQ-014 SHALL have port tick output 1: registered prescaler step strobe.

Function
REQ-015 SHALL apply priority per edge: Reset > load > step > hold.
REQ-016 SHALL, on load, set count to load_val if load_val < MODULUS, else MODULUS-1; prescaler counter cleared; no step that cycle.
REQ-017 SHALL step only in a cycle where en=1 and tick=1 and load=0.
REQ-018 SHALL hold prescaler while en=0; with en=1, assert tick once every DIV cycles (DIV=1: tick=1 every cycle with en=1 held).
REQ-019 SHALL step up: count+1, or at MODULUS-1 go to 0 (sat_mode=0) or hold MODULUS-1 (sat_mode=1).
REQ-020 SHALL step down: count-1, or at 0 go to MODULUS-1 (sat_mode=0) or hold 0 (sat_mode=1).
REQ-021 SHALL assert wrap_pulse for exactly the one cycle after a wrap transition; never on saturate-hold or load.
REQ-022 SHALL drive tc = en & tick & (up_dn ? count==MODULUS-1 : count==0), independent of sat_mode.
REQ-023 SHALL compute next count at WIDTH+1 bits internally; no out-of-range count value ever observable.
REQ-024 SHALL apply a direction change in the cycle up_dn changes, with no extra latency.
REQ-025 SHALL treat load=1 with en=1 on a terminal value as load only: no wrap_pulse, no step.

Reset
REQ-026 SHALL on Reset=1 at an edge set count=0, wrap_pulse=0, tick=0, prescaler counter=0, regardless of load/en.
REQ-027 SHALL give tc=0 while Reset is held (tick=0).
REQ-028 SHALL resume stepping on the first enabled tick after Reset deasserts; no asynchronous paths.

Structure
REQ-029 SHALL place direction encoding constants (DIR_UP=1, DIR_DN=0) and a clamp helper function in shared package counter_pkg.
REQ-030 SHALL implement the prescaler as sub-module count_prescaler (params DIV; ports clk1, Reset, en, clr, tick).
REQ-031 SHALL use one always block per register group; tc purely combinational.

Verification (WIDTH=4, MODULUS=10, DIV=1 unless stated)
REQ-032 SHALL check: Reset 2 cycles, en=1, up_dn=1, sat_mode=0 for 12 cycles -> count 1..9,0,1,2; wrap_pulse high only the cycle count reads 0 first time.
REQ-033 SHALL check: from count=0, up_dn=0, sat_mode=1, en=1 for 3 cycles -> count stays 0, wrap_pulse=0, tc=1 each cycle.
REQ-034 SHALL check: load=1, load_val=7, en=1 same cycle -> count=7 next cycle, no step; then load_val=12 -> count=9.
REQ-035 SHALL check: DIV=3, en=1 up from 0 for 9 cycles -> tick every 3rd cycle, count ends at 3; en=0 for 5 cycles -> count and prescaler frozen.
REQ-036 SHALL check: count=5 counting, Reset=1 with load=1, load_val=3 -> count=0, wrap_pulse=0 next cycle.
REQ-037 SHALL check: two instances cascaded (high en = low tc) over 100 enabled cycles -> combined value 00..99 then wraps to 00.
